// File: rtl/dmem_lane_ctrl_if.sv
// Request/response bundle between the MEM stage and dmem_lane_ctrl.
interface dmem_lane_ctrl_if #(parameter int ADDR_WIDTH = 12);
  logic                  req;
  logic                  memWrite;
  logic [ADDR_WIDTH-1:0] Addr;
  logic [1:0]            Mode;
  logic                  sign_ext;
  logic [31:0]           data_in;
  logic                  ready;
  logic                  resp_valid;
  logic [31:0]           data_out;
  logic                  err;
  logic                  busy;

  modport master (
    output req, memWrite, Addr, Mode, sign_ext, data_in,
    input  ready, resp_valid, data_out, err, busy
  );

  modport slave (
    input  req, memWrite, Addr, Mode, sign_ext, data_in,
    output ready, resp_valid, data_out, err, busy
  );
endinterface

// File: rtl/dmem_lane_ctrl.sv
// Byte/half/word data memory with req/ready handshake, registered read
// response, access error reporting and an optional zeroing sweep after reset.
module dmem_lane_ctrl #(
  parameter int ADDR_WIDTH     = 12,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic            clk,
  input logic            clr,
  dmem_lane_ctrl_if.slave bus
);
  localparam int IW    = ADDR_WIDTH - 2;
  localparam int WORDS = 2 ** IW;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] cnt_q;
  logic [31:0]   mem [WORDS];
  logic [31:0]   rd_word;

  logic          acc, bad, wr, rd;
  logic [IW-1:0] idx;
  logic [3:0]    be;
  logic [31:0]   wdat;

  logic          rsp_q, err_q, ld_q, sx_q;
  logic [1:0]    mode_q, lane_q;
  logic [31:0]   hold_q, fmt;
  logic [7:0]    bsel;
  logic [15:0]   hsel;

  // FSM
  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_q <= CLEAR_ON_RESET ? CLEAR : IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CLEAR:   if (&cnt_q) state_d = IDLE;
      IDLE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr)                 cnt_q <= '0;
    else if (state_q == CLEAR) cnt_q <= cnt_q + 1'b1;
  end

  // ready drops combinationally with clr so nothing is accepted during reset
  assign bus.ready = (state_q == IDLE) & ~clr;
  assign bus.busy  = (state_q == CLEAR);

  assign acc = bus.ready & bus.req;
  assign idx = bus.Addr[ADDR_WIDTH-1:2];
  assign bad = (bus.Mode == 2'b11) |
               ((bus.Mode == 2'b01) & bus.Addr[0]) |
               ((bus.Mode == 2'b10) & (|bus.Addr[1:0]));
  assign wr  = acc &  bus.memWrite & ~bad;
  assign rd  = acc & ~bus.memWrite & ~bad;

  always_comb begin
    be   = 4'b0000;
    wdat = bus.data_in;
    case (bus.Mode)
      2'b00: begin
        be   = 4'b0001 << bus.Addr[1:0];
        wdat = {4{bus.data_in[7:0]}};
      end
      2'b01: begin
        be   = bus.Addr[1] ? 4'b1100 : 4'b0011;
        wdat = {2{bus.data_in[15:0]}};
      end
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
  end

  // Array kept free of reset so it maps onto block RAM with byte enables
  always_ff @(posedge clk) begin
    if (state_q == CLEAR) mem[cnt_q] <= '0;
    else if (wr)
      for (int l = 0; l < 4; l++)
        if (be[l]) mem[idx][8*l +: 8] <= wdat[8*l +: 8];
    if (rd) rd_word <= mem[idx];
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      rsp_q  <= 1'b0;
      err_q  <= 1'b0;
      ld_q   <= 1'b0;
      sx_q   <= 1'b0;
      mode_q <= 2'b00;
      lane_q <= 2'b00;
      hold_q <= '0;
    end else begin
      rsp_q <= acc;
      if (acc) begin
        err_q  <= bad;
        ld_q   <= rd;
        sx_q   <= bus.sign_ext;
        mode_q <= bus.Mode;
        lane_q <= bus.Addr[1:0];
      end
      if (rsp_q) hold_q <= fmt;
    end
  end

  // Lane extraction happens after the RAM output register
  always_comb begin
    fmt  = '0;
    bsel = rd_word[8*lane_q +: 8];
    hsel = lane_q[1] ? rd_word[31:16] : rd_word[15:0];
    if (ld_q) begin
      case (mode_q)
        2'b00:   fmt = {{24{sx_q & bsel[7]}}, bsel};
        2'b01:   fmt = {{16{sx_q & hsel[15]}}, hsel};
        default: fmt = rd_word;
      endcase
    end
  end

  assign bus.resp_valid = rsp_q;
  assign bus.err        = rsp_q & err_q;
  assign bus.data_out   = rsp_q ? fmt : hold_q;
endmodule
